// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EX stage and the sequential multiply/divide unit.
interface mdu_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  // Requester side: issues operations, consumes results, may flush.
  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Unit side.
  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential 64-bit multiply/divide unit: shift-add multiply and restoring divide,
// one step per cycle, with early-out for divide-by-zero and signed overflow.
module mdu_seq (
  input  logic      clk,
  input  logic      rst_n,
  mdu_seq_if.slave  bus
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned ACC_W = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;       // mul: {product hi, product lo / multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2:0]        op_q;
  logic              neg_q;     // negate product / quotient
  logic              neg_r;     // negate remainder
  logic [XLEN-1:0]   result_q;

  logic              accept_c;
  logic              is_div_c;
  logic              signed_a_c;
  logic              signed_b_c;
  logic              sa_c;
  logic              sb_c;
  logic [XLEN-1:0]   mag_a_c;
  logic [XLEN-1:0]   mag_b_c;
  logic              div_zero_c;
  logic              div_ovf_c;
  logic [XLEN:0]     mul_sum_c;
  logic [XLEN:0]     div_shift_c;
  logic [XLEN:0]     div_diff_c;
  logic [ACC_W-1:0]  acc_step_c;
  logic [ACC_W-1:0]  prod_fix_c;
  logic [XLEN-1:0]   quo_fix_c;
  logic [XLEN-1:0]   rem_fix_c;
  logic [XLEN-1:0]   res_fix_c;

  // Request decode: signedness, operand magnitudes and early-out detection.
  always_comb begin
    accept_c   = bus.in_valid && bus.in_ready;
    is_div_c   = bus.op[2];
    signed_a_c = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                 (bus.op == OP_DIV)  || (bus.op == OP_REM);
    signed_b_c = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    sa_c       = signed_a_c && bus.a[XLEN-1];
    sb_c       = signed_b_c && bus.b[XLEN-1];
    mag_a_c    = sa_c ? (~bus.a + XLEN'(1)) : bus.a;
    mag_b_c    = sb_c ? (~bus.b + XLEN'(1)) : bus.b;
    div_zero_c = is_div_c && (bus.b == '0);
    div_ovf_c  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.a == INT_MIN) && (bus.b == '1);
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_c   = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
    div_shift_c = acc[ACC_W-1:XLEN-1];
    div_diff_c  = div_shift_c - {1'b0, opnd};
    if (op_q[2]) begin
      if (div_diff_c[XLEN])
        acc_step_c = {div_shift_c[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_step_c = {div_diff_c[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step_c = {mul_sum_c, acc[XLEN-1:1]};
    end
  end

  // Sign correction and result selection.
  always_comb begin
    prod_fix_c = neg_q ? (~acc + ACC_W'(1)) : acc;
    quo_fix_c  = neg_q ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_fix_c  = neg_r ? (~acc[ACC_W-1:XLEN] + XLEN'(1)) : acc[ACC_W-1:XLEN];
    case (op_q)
      OP_MUL:                        res_fix_c = prod_fix_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res_fix_c = prod_fix_c[ACC_W-1:XLEN];
      OP_DIV, OP_DIVU:               res_fix_c = quo_fix_c;
      default:                       res_fix_c = rem_fix_c;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept_c) state_nxt = (div_zero_c || div_ovf_c) ? FIX : CALC;
        CALC: if (cnt == LAST_CNT) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (bus.out_ready) state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: latch on accept, iterate in CALC, register the corrected result in FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (accept_c) begin
      op_q <= bus.op;
      cnt  <= '0;
      if (div_zero_c) begin
        // Quotient all ones, remainder is the raw dividend.
        acc   <= {bus.a, {XLEN{1'b1}}};
        opnd  <= '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (div_ovf_c) begin
        acc   <= {{XLEN{1'b0}}, INT_MIN};
        opnd  <= '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        acc   <= is_div_c ? {{XLEN{1'b0}}, mag_a_c} : {{XLEN{1'b0}}, mag_b_c};
        opnd  <= is_div_c ? mag_b_c : mag_a_c;
        neg_q <= sa_c ^ sb_c;
        neg_r <= sa_c;
      end
    end else if (state == CALC && !bus.flush) begin
      acc <= acc_step_c;
      cnt <= cnt + CNT_W'(1);
    end else if (state == FIX && !bus.flush) begin
      result_q <= res_fix_c;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !bus.flush;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised and directed checks of mdu_seq against an arithmetic reference model.
module tb_mdu_seq;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  mdu_seq_if bus ();

  mdu_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide arithmetic on the architectural definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic signed [127:0] ub_s;
    logic signed [127:0] p_ss;
    logic signed [127:0] p_su;
    logic [127:0]        p_uu;
    logic signed [63:0]  as;
    logic signed [63:0]  bs;
    logic signed [63:0]  q;
    as   = a;
    bs   = b;
    sa   = {{64{a[63]}}, a};
    sb   = {{64{b[63]}}, b};
    ub_s = {64'd0, b};
    p_ss = sa * sb;
    p_su = sa * ub_s;
    p_uu = {64'd0, a} * {64'd0, b};
    case (op)
      3'd0: return p_uu[63:0];
      3'd1: return p_ss[127:64];
      3'd2: return p_su[127:64];
      3'd3: return p_uu[127:64];
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return MINV;
        q = as / bs;
        return q;
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return 64'd0;
        q = as % bs;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MINV && b == ONES) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'd1;
      4: return 64'($urandom_range(0, 20));
      5: return 64'd0 - 64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request, measure latency, check result, optionally stall in DONE, then retire.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int hold);
    int          lat;
    logic [63:0] r0;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1 || 1) step();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(op, a, b)));
    chk({tag, " result"}, bus.result, exp_res);
    r0 = bus.result;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " hold result"}, bus.result, r0);
      chk({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " hold busy"}, 64'(bus.busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, " retire valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " retire busy"}, 64'(bus.busy), 64'd0);
    if (lat == 0) begin
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
    end
  endtask

  // Count out_valid assertions over a window; must be none.
  task automatic quiet_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 64'd0;
    bus.b         = 64'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset result", bus.result, 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);

    // Directed arithmetic
    run_op("mul neg", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("mulhu max", 3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("div -7/2", 3'd4, 64'd0 - 64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem -7%2", 3'd6, 64'd0 - 64'd7, 64'd2, ONES, 0);
    run_op("divu 100/7", 3'd5, 64'd100, 64'd7, 64'd14, 10);
    run_op("divu by 0", 3'd5, 64'd5, 64'd0, ONES, 0);
    run_op("remu by 0", 3'd7, 64'd5, 64'd0, 64'd5, 0);
    run_op("div ovf", 3'd4, MINV, ONES, MINV, 0);
    run_op("rem ovf", 3'd6, MINV, ONES, 64'd0, 0);
    run_op("mul by 0", 3'd0, {$urandom, $urandom}, 64'd0, 64'd0, 0);

    // Flush during CALC at step 30
    bus.op = 3'd0; bus.a = 64'd99; bus.b = 64'd77; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (30) step();
    chk("flush pre busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    chk("flush in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'd0);
    quiet_window("flush no valid", 70);
    run_op("mul 3*4", 3'd0, 64'd3, 64'd4, 64'd12, 0);

    // Flush with in_valid in IDLE accepts nothing
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'd5; bus.b = 64'd0;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("idle flush busy", 64'(bus.busy), 64'd0);
    quiet_window("idle flush no valid", 4);

    // Flush coincident with out_ready in DONE
    bus.op = 3'd5; bus.a = 64'd9; bus.b = 64'd0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("done flush pre valid", 64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    chk("done flush busy", 64'(bus.busy), 64'd0);
    chk("done flush valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-CALC
    bus.op = 3'd2; bus.a = 64'd123; bus.b = 64'd456; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid rst busy", 64'(bus.busy), 64'd0);
    chk("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid rst result", bus.result, 64'd0);
    chk("mid rst in_ready", 64'(bus.in_ready), 64'd1);
    quiet_window("mid rst no valid", 70);

    // Randomised operations against the reference model
    for (int t = 0; t < 150; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rand_opnd();
      rb  = rand_opnd();
      run_op($sformatf("rand%0d op%0d", t, rop), rop, ra, rb, ref_model(rop, ra, rb),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
